// File: rtl/hart_sched_pkg.sv
// rtl/hart_sched_pkg.sv - shared types, sizes and next-state rule for the hart scheduler
//
// Purpose: hart lifecycle encoding, default hart count/id width, wait-counter
//          saturation value and the per-hart event-priority function.
// Ports:   none (package).

package hart_sched_pkg;

  localparam int HART_NUM_DEF  = 4;
  localparam int HART_ID_W_DEF = 2;
  localparam logic [3:0] WAIT_MAX = 4'd15;

  typedef enum logic [1:0] {
    HART_STATE_IDLE   = 2'b00,
    HART_STATE_ACTIVE = 2'b01,
    HART_STATE_PEND   = 2'b10
  } hart_state_e;

  // Event priority: kill, miss, done, start. A miss on a PEND hart keeps it
  // PEND, which also means a same-cycle miss masks a refill completion.
  function automatic hart_state_e hart_next_state(input hart_state_e cur,
                                                  input logic kill,
                                                  input logic miss,
                                                  input logic done,
                                                  input logic start);
    hart_state_e nxt;
    nxt = cur;
    if (kill)
      nxt = HART_STATE_IDLE;
    else if (miss && cur != HART_STATE_IDLE)
      nxt = HART_STATE_PEND;
    else if (done && cur == HART_STATE_PEND)
      nxt = HART_STATE_ACTIVE;
    else if (start && cur == HART_STATE_IDLE)
      nxt = HART_STATE_ACTIVE;
    return nxt;
  endfunction

endpackage

// File: rtl/hart_sched_if.sv
// rtl/hart_sched_if.sv - scheduler bundle: ID start/kill, I-cache miss/refill, IF-stage results
//
// Purpose: groups every scheduler signal except clk/reset.
// Ports (slave = scheduler view):
//   in : stall, hs_en/hs_id, hk_en/hk_id, cm_en/cm_hart_id, cm_done/cm_done_id
//   out: hart_id, issue_en, hs_ack, hart_idle, hart_pend

interface hart_sched_if #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2
);
  logic                 stall;
  logic                 hs_en;
  logic [HART_ID_W-1:0] hs_id;
  logic                 hk_en;
  logic [HART_ID_W-1:0] hk_id;
  logic                 cm_en;
  logic [HART_ID_W-1:0] cm_hart_id;
  logic                 cm_done;
  logic [HART_ID_W-1:0] cm_done_id;
  logic [HART_ID_W-1:0] hart_id;
  logic                 issue_en;
  logic                 hs_ack;
  logic [HART_NUM-1:0]  hart_idle;
  logic [HART_NUM-1:0]  hart_pend;

  modport master (
    output stall, hs_en, hs_id, hk_en, hk_id, cm_en, cm_hart_id, cm_done, cm_done_id,
    input  hart_id, issue_en, hs_ack, hart_idle, hart_pend
  );

  modport slave (
    input  stall, hs_en, hs_id, hk_en, hk_id, cm_en, cm_hart_id, cm_done, cm_done_id,
    output hart_id, issue_en, hs_ack, hart_idle, hart_pend
  );
endinterface

// File: rtl/hart_sched_rr_pick.sv
// rtl/hart_sched_rr_pick.sv - combinational rotating-priority picker (module hart_rr_pick)
//
// Purpose: grant the first requester after last, wrapping; last is checked last.
// Ports:
//   in : req[N-1:0] request vector, last[W-1:0] previous grant id
//   out: gnt_id[W-1:0] granted id (equals last when nothing requests), gnt_vld

module hart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_id,
  output logic         gnt_vld
);

  logic [W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is the
  // last write. Offset N wraps to last itself because N == 2**W.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = last;
    cand    = last;
    for (int off = N; off >= 1; off--) begin
      cand = last + W'(off);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

endmodule

// File: rtl/hart_sched.sv
// rtl/hart_sched.sv - per-cycle hart lifecycle tracker and round-robin fetch selector
//
// Purpose: keeps each hart IDLE/ACTIVE/PEND from ID start/kill and I-cache
//          miss/refill events, then registers the next ACTIVE hart for IF.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   bus (slave)       inputs stall, hs_*, hk_*, cm_*; outputs hart_id,
//                     issue_en, hs_ack, hart_idle, hart_pend
// Option: HART_SCHED_FAIR_EN adds 4-bit per-hart wait counters; a hart whose
//         counter reaches 15 preempts round-robin (lowest id on ties).

module hart_sched
  import hart_sched_pkg::*;
#(
  parameter int HART_NUM  = HART_NUM_DEF,
  parameter int HART_ID_W = HART_ID_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  hart_sched_if.slave bus
);

  hart_state_e          st_q [HART_NUM];
  hart_state_e          st_d [HART_NUM];
  logic [HART_NUM-1:0]  req;
  logic                 hs_ack_d;
  logic [HART_ID_W-1:0] rr_id;
  logic                 rr_vld;
  logic [HART_ID_W-1:0] sel_id;
  logic                 sel_vld;

  // Next-state per hart; selection looks at next state so a hart that
  // misses this cycle is never issued next cycle.
  always_comb begin
    for (int i = 0; i < HART_NUM; i++) begin
      st_d[i] = hart_next_state(st_q[i],
                                bus.hk_en   && bus.hk_id      == HART_ID_W'(i),
                                bus.cm_en   && bus.cm_hart_id == HART_ID_W'(i),
                                bus.cm_done && bus.cm_done_id == HART_ID_W'(i),
                                bus.hs_en   && bus.hs_id      == HART_ID_W'(i));
      req[i]  = (st_d[i] == HART_STATE_ACTIVE);
    end
  end

  // A start was accepted only if it actually moved the hart out of IDLE
  // (a same-cycle kill leaves it IDLE).
  assign hs_ack_d = bus.hs_en && st_q[bus.hs_id] == HART_STATE_IDLE
                    && st_d[bus.hs_id] == HART_STATE_ACTIVE;

  hart_rr_pick #(.N(HART_NUM), .W(HART_ID_W)) u_pick (
    .req     (req),
    .last    (bus.hart_id),
    .gnt_id  (rr_id),
    .gnt_vld (rr_vld)
  );

`ifdef HART_SCHED_FAIR_EN
  logic [3:0]           wait_q [HART_NUM];
  logic                 starve_vld;
  logic [HART_ID_W-1:0] starve_id;

  // Descending scan so the lowest starved id wins.
  always_comb begin
    starve_vld = 1'b0;
    starve_id  = '0;
    for (int i = HART_NUM - 1; i >= 0; i--) begin
      if (req[i] && wait_q[i] == WAIT_MAX) begin
        starve_vld = 1'b1;
        starve_id  = HART_ID_W'(i);
      end
    end
  end

  assign sel_id  = starve_vld ? starve_id : rr_id;
  assign sel_vld = rr_vld;

  // Counters hold while a hart is not ACTIVE so a hart repeatedly bounced
  // through PEND just before its turn still accumulates wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HART_NUM; i++) wait_q[i] <= '0;
    end else if (!bus.stall) begin
      for (int i = 0; i < HART_NUM; i++) begin
        if (sel_vld && sel_id == HART_ID_W'(i))
          wait_q[i] <= '0;
        else if (req[i] && wait_q[i] != WAIT_MAX)
          wait_q[i] <= wait_q[i] + 4'd1;
      end
    end
  end
`else
  assign sel_id  = rr_id;
  assign sel_vld = rr_vld;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HART_NUM; i++)
        st_q[i] <= (i == 0) ? HART_STATE_ACTIVE : HART_STATE_IDLE;
      bus.hart_id  <= '0;
      bus.issue_en <= 1'b1;
      bus.hs_ack   <= 1'b0;
    end else begin
      for (int i = 0; i < HART_NUM; i++) st_q[i] <= st_d[i];
      bus.hs_ack <= hs_ack_d;
      if (!bus.stall) begin
        bus.issue_en <= sel_vld;
        if (sel_vld) bus.hart_id <= sel_id;
      end
    end
  end

  always_comb begin
    bus.hart_idle = '0;
    bus.hart_pend = '0;
    for (int i = 0; i < HART_NUM; i++) begin
      bus.hart_idle[i] = (st_q[i] == HART_STATE_IDLE);
      bus.hart_pend[i] = (st_q[i] == HART_STATE_PEND);
    end
  end

endmodule

// File: tb/tb_hart_sched.sv
// tb/tb_hart_sched.sv - scoreboard bench for hart_sched with directed vectors

module tb_hart_sched;

`ifdef HART_SCHED_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    int         step;
    logic [1:0] hid;
    logic       iss;
    logic       ack;
    logic [3:0] idle;
    logic [3:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   step_no = 0;

  hart_sched_if #(.HART_NUM(4), .HART_ID_W(2)) bus ();

  hart_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b, expected %b", name, step, act, req);
    end
  endtask

  // Monitor: outputs are produced every cycle, compare 1 ns after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hart_id",   e.step, {2'b00, bus.hart_id}, {2'b00, e.hid});
        chk("issue_en",  e.step, {3'b000, bus.issue_en}, {3'b000, e.iss});
        chk("hs_ack",    e.step, {3'b000, bus.hs_ack}, {3'b000, e.ack});
        chk("hart_idle", e.step, bus.hart_idle, e.idle);
        chk("hart_pend", e.step, bus.hart_pend, e.pend);
      end
    end
  end

  // One cycle: drive inputs at negedge, queue the outputs expected after the next posedge.
  task automatic cyc(input logic rst, input logic stl,
                     input logic hse, input logic [1:0] hsi,
                     input logic hke, input logic [1:0] hki,
                     input logic cme, input logic [1:0] cmi,
                     input logic cde, input logic [1:0] cdi,
                     input logic [1:0] hid, input logic iss, input logic ack,
                     input logic [3:0] idle, input logic [3:0] pend);
    exp_t e;
    @(negedge clk);
    reset = rst; bus.stall = stl;
    bus.hs_en = hse; bus.hs_id = hsi;
    bus.hk_en = hke; bus.hk_id = hki;
    bus.cm_en = cme; bus.cm_hart_id = cmi;
    bus.cm_done = cde; bus.cm_done_id = cdi;
    step_no++;
    e.step = step_no; e.hid = hid; e.iss = iss; e.ack = ack; e.idle = idle; e.pend = pend;
    exp_q.push_back(e);
  endtask

  // Shorthand for a quiet cycle with only the expected outputs.
  task automatic nop(input logic [1:0] hid, input logic iss, input logic [3:0] idle, input logic [3:0] pend);
    cyc(0,0, 0,0, 0,0, 0,0, 0,0, hid, iss, 1'b0, idle, pend);
  endtask

  initial begin
    bus.stall = 0; bus.hs_en = 0; bus.hs_id = 0; bus.hk_en = 0; bus.hk_id = 0;
    bus.cm_en = 0; bus.cm_hart_id = 0; bus.cm_done = 0; bus.cm_done_id = 0;

    // reset state
    cyc(1,0, 0,0, 0,0, 0,0, 0,0, 2'd0,1,0,4'b1110,4'b0000);
    // start hart 2, then alternate 2,0,2,0
    cyc(0,0, 1,2, 0,0, 0,0, 0,0, 2'd2,1,1,4'b1010,4'b0000);
    nop(2'd0,1,4'b1010,4'b0000);
    nop(2'd2,1,4'b1010,4'b0000);
    nop(2'd0,1,4'b1010,4'b0000);
    // bring up harts 1 and 3
    cyc(0,0, 1,1, 0,0, 0,0, 0,0, 2'd1,1,1,4'b1000,4'b0000);
    cyc(0,0, 1,3, 0,0, 0,0, 0,0, 2'd2,1,1,4'b0000,4'b0000);
    nop(2'd3,1,4'b0000,4'b0000);
    nop(2'd0,1,4'b0000,4'b0000);
    // miss on hart 1 while hart_id=0: 2,3,0,2 then refill returns it
    cyc(0,0, 0,0, 0,0, 1,1, 0,0, 2'd2,1,0,4'b0000,4'b0010);
    nop(2'd3,1,4'b0000,4'b0010);
    nop(2'd0,1,4'b0000,4'b0010);
    nop(2'd2,1,4'b0000,4'b0010);
    cyc(0,0, 0,0, 0,0, 0,0, 1,1, 2'd3,1,0,4'b0000,4'b0000);
    nop(2'd0,1,4'b0000,4'b0000);
    nop(2'd1,1,4'b0000,4'b0000);
    nop(2'd2,1,4'b0000,4'b0000);
    // kill harts 1..3
    cyc(0,0, 0,0, 1,1, 0,0, 0,0, 2'd3,1,0,4'b0010,4'b0000);
    cyc(0,0, 0,0, 1,2, 0,0, 0,0, 2'd0,1,0,4'b0110,4'b0000);
    cyc(0,0, 0,0, 1,3, 0,0, 0,0, 2'd0,1,0,4'b1110,4'b0000);
    // only hart 0 active: miss -> nothing to issue, id holds
    cyc(0,0, 0,0, 0,0, 1,0, 0,0, 2'd0,0,0,4'b1110,4'b0001);
    nop(2'd0,0,4'b1110,4'b0001);
    cyc(0,0, 0,0, 0,0, 0,0, 1,0, 2'd0,1,0,4'b1110,4'b0000);
    // stall 3 cycles with a start of hart 3 in the first
    cyc(0,1, 1,3, 0,0, 0,0, 0,0, 2'd0,1,1,4'b0110,4'b0000);
    cyc(0,1, 0,0, 0,0, 0,0, 0,0, 2'd0,1,0,4'b0110,4'b0000);
    cyc(0,1, 0,0, 0,0, 0,0, 0,0, 2'd0,1,0,4'b0110,4'b0000);
    nop(2'd3,1,4'b0110,4'b0000);
    nop(2'd0,1,4'b0110,4'b0000);
    // kill and start on idle hart 1 together: kill wins
    cyc(0,0, 1,1, 1,1, 0,0, 0,0, 2'd3,1,0,4'b0110,4'b0000);
    // refill for idle hart 2 ignored
    cyc(0,0, 0,0, 0,0, 0,0, 1,2, 2'd0,1,0,4'b0110,4'b0000);
    // miss on idle hart 1 ignored
    cyc(0,0, 0,0, 0,0, 1,1, 0,0, 2'd3,1,0,4'b0110,4'b0000);
    // kill beats miss on hart 3
    cyc(0,0, 0,0, 1,3, 1,3, 0,0, 2'd0,1,0,4'b1110,4'b0000);
    // pending refill discarded by reset; late cm_done ignored; start on active hart refused
    cyc(0,0, 0,0, 0,0, 1,0, 0,0, 2'd0,0,0,4'b1110,4'b0001);
    cyc(1,0, 0,0, 0,0, 0,0, 0,0, 2'd0,1,0,4'b1110,4'b0000);
    cyc(0,0, 0,0, 0,0, 0,0, 1,0, 2'd0,1,0,4'b1110,4'b0000);
    cyc(0,0, 1,0, 0,0, 0,0, 0,0, 2'd0,1,0,4'b1110,4'b0000);

    // Starvation pattern: hart 2 is bounced through PEND just before its turn.
    cyc(1,0, 0,0, 0,0, 0,0, 0,0, 2'd0,1,0,4'b1110,4'b0000);
    cyc(0,0, 1,2, 0,0, 0,0, 0,0, 2'd2,1,1,4'b1010,4'b0000);
    cyc(0,0, 1,1, 0,0, 0,0, 0,0, 2'd0,1,1,4'b1000,4'b0000);
    nop(2'd1,1,4'b1000,4'b0000);
    for (int j = 1; j <= 14; j++) begin
      cyc(0,0, 0,0, 0,0, 1,2, 0,0, 2'd0,1,0,4'b1000,4'b0100);
      cyc(0,0, 0,0, 0,0, 0,0, 1,2, (FAIR && j == 14) ? 2'd2 : 2'd1,1,0,4'b1000,4'b0000);
    end
    nop(FAIR ? 2'd0 : 2'd2,1,4'b1000,4'b0000);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
